// File: rtl/detect_programmable_sequence_using_shift_reg_if.sv
// Configuration and serial-stream bundle for the programmable sequence detector.
// The master drives the config and bit stream; the slave returns the registered status.
interface detect_programmable_sequence_using_shift_reg_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               bit_valid;
  logic               new_bit;
  logic               detected;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, bit_valid, new_bit,
    input  cfg_err, detected, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, bit_valid, new_bit,
    output cfg_err, detected, match_cnt
  );
endinterface

// File: rtl/detect_programmable_sequence_using_shift_reg.sv
// Serial sequence detector with run-time pattern/length, overlap mode and a
// saturating match counter. All outputs are registered.
module detect_programmable_sequence_using_shift_reg #(
  parameter int               MAX_LEN     = 16,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 16'b110011,
  parameter int               DEF_LEN     = 6,
  parameter bit               DEF_OVERLAP = 1'b1
) (
  input logic clk,
  input logic rst,
  detect_programmable_sequence_using_shift_reg_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] shift_q,   shift_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;
  logic               detected_q, detected_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] shifted;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;
  logic               cfg_ok;

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    shifted  = {shift_q[MAX_LEN-2:0], bus.new_bit};
    fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    // Fill guard keeps zero-initialised history from matching all-zero patterns.
    hit      = ((shifted & len_mask) == (pattern_q & len_mask)) && (fill_inc >= len_q);
    cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  end

  always_comb begin
    shift_d    = shift_q;
    fill_d     = fill_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    overlap_d  = overlap_q;
    detected_d = 1'b0;
    cfg_err_d  = 1'b0;
    cnt_d      = cnt_q;

    if (bus.cfg_we) begin
      if (cfg_ok) begin
        pattern_d = bus.cfg_pattern;
        len_d     = bus.cfg_len;
        overlap_d = bus.cfg_overlap;
        shift_d   = '0;
        fill_d    = '0;
        cnt_d     = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (bus.bit_valid) begin
      shift_d = shifted;
      fill_d  = fill_inc;
      if (hit) begin
        detected_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!overlap_q) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      fill_q     <= '0;
      pattern_q  <= DEF_PATTERN;
      len_q      <= LEN_W'(DEF_LEN);
      overlap_q  <= DEF_OVERLAP;
      detected_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      shift_q    <= shift_d;
      fill_q     <= fill_d;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      overlap_q  <= overlap_d;
      detected_q <= detected_d;
      cfg_err_q  <= cfg_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.detected  = detected_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_detect_programmable_sequence_using_shift_reg.sv
// Directed testbench for the programmable sequence detector (CNT_W=2 so that
// counter saturation is reachable in a few matches).
module tb_detect_programmable_sequence_using_shift_reg;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  detect_programmable_sequence_using_shift_reg_if #(.MAX_LEN(16), .CNT_W(2)) ifc ();

  detect_programmable_sequence_using_shift_reg #(.MAX_LEN(16), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic drive(input logic we, input logic [15:0] pat, input logic [4:0] len,
                       input logic ovl, input logic v, input logic b);
    @(negedge clk);
    ifc.cfg_we      = we;
    ifc.cfg_pattern = pat;
    ifc.cfg_len     = len;
    ifc.cfg_overlap = ovl;
    ifc.bit_valid   = v;
    ifc.new_bit     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b1, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifc.cfg_we = 1'b0; ifc.bit_valid = 1'b0; ifc.new_bit = 1'b0;
    ifc.cfg_pattern = '0; ifc.cfg_len = '0; ifc.cfg_overlap = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (ifc.detected !== 1'b0 || ifc.cfg_err !== 1'b0 || ifc.match_cnt !== 2'd0) begin
      nerr++;
      $display("FAIL reset: det=%b err=%b cnt=%0d, want 0 0 0", ifc.detected, ifc.cfg_err, ifc.match_cnt);
    end
  endtask

  task automatic test_default();
    logic [5:0] seq;
    seq = 6'b110011;
    for (int i = 5; i >= 0; i--) begin
      send(seq[i]);
      nvec++;
      if (ifc.detected !== (i == 0)) begin
        nerr++;
        $display("FAIL default_det bit %0d: got %b want %b", 6 - i, ifc.detected, (i == 0));
      end
    end
    nvec++;
    if (ifc.match_cnt !== 2'd1) begin
      nerr++;
      $display("FAIL default_cnt: got %0d want 1", ifc.match_cnt);
    end
  endtask

  task automatic test_overlap(input logic ovl);
    logic [7:0] exp;
    exp = ovl ? 8'b1010_1000 : 8'b1000_1000; // bit 0 = first bit sent
    drive(1'b1, 16'b1010, 5'd4, ovl, 1'b0, 1'b0);
    nvec++;
    if (ifc.match_cnt !== 2'd0 || ifc.cfg_err !== 1'b0) begin
      nerr++;
      $display("FAIL ovl%0b_cfg: cnt=%0d err=%b want 0 0", ovl, ifc.match_cnt, ifc.cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      send((i % 2) == 0);
      nvec++;
      if (ifc.detected !== exp[i]) begin
        nerr++;
        $display("FAIL ovl%0b_det bit %0d: got %b want %b", ovl, i + 1, ifc.detected, exp[i]);
      end
    end
    nvec++;
    if (ifc.match_cnt !== (ovl ? 2'd3 : 2'd2)) begin
      nerr++;
      $display("FAIL ovl%0b_cnt: got %0d want %0d", ovl, ifc.match_cnt, ovl ? 3 : 2);
    end
  endtask

  task automatic test_fill_guard();
    logic [5:0] v, e;
    drive(1'b1, 16'b000, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0);
      nvec++;
      if (ifc.detected !== (i == 2)) begin
        nerr++;
        $display("FAIL fill_det zero %0d: got %b want %b", i + 1, ifc.detected, (i == 2));
      end
    end
    // Interleave invalid ones between valid zeros: only valid bits count.
    drive(1'b1, 16'b000, 5'd3, 1'b1, 1'b0, 1'b0);
    v = 6'b100101; // bit 0 applied first
    e = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'h0, 5'd0, 1'b0, v[i], ~v[i]);
      nvec++;
      if (ifc.detected !== e[i]) begin
        nerr++;
        $display("FAIL gap_det step %0d: got %b want %b", i, ifc.detected, e[i]);
      end
    end
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (ifc.detected !== 1'b0) begin
      nerr++;
      $display("FAIL gap_hold: got %b want 0", ifc.detected);
    end
    send(1'b0);
    nvec++;
    if (ifc.detected !== 1'b1 || ifc.match_cnt !== 2'd2) begin
      nerr++;
      $display("FAIL gap_overlap: det=%b cnt=%0d want 1 2", ifc.detected, ifc.match_cnt);
    end
  endtask

  task automatic test_illegal_cfg();
    logic [4:0] seq;
    do_reset();
    seq = 5'b11001;
    for (int i = 4; i >= 0; i--) send(seq[i]);
    drive(1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b1, 1'b1);
    nvec++;
    if (ifc.cfg_err !== 1'b1 || ifc.detected !== 1'b0) begin
      nerr++;
      $display("FAIL err_len0: err=%b det=%b want 1 0", ifc.cfg_err, ifc.detected);
    end
    drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (ifc.cfg_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pulse: got %b want 0", ifc.cfg_err);
    end
    drive(1'b1, 16'hFFFF, 5'd17, 1'b0, 1'b1, 1'b1);
    nvec++;
    if (ifc.cfg_err !== 1'b1 || ifc.detected !== 1'b0) begin
      nerr++;
      $display("FAIL err_len17: err=%b det=%b want 1 0", ifc.cfg_err, ifc.detected);
    end
    send(1'b1);
    nvec++;
    if (ifc.detected !== 1'b1 || ifc.match_cnt !== 2'd1 || ifc.cfg_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_keep: det=%b cnt=%0d err=%b want 1 1 0", ifc.detected, ifc.match_cnt, ifc.cfg_err);
    end
    // Legal cfg with a same-cycle valid 1: that bit must not enter history.
    drive(1'b1, 16'b110011, 5'd6, 1'b1, 1'b1, 1'b1);
    nvec++;
    if (ifc.match_cnt !== 2'd0 || ifc.cfg_err !== 1'b0) begin
      nerr++;
      $display("FAIL cfg_clear: cnt=%0d err=%b want 0 0", ifc.match_cnt, ifc.cfg_err);
    end
    seq = 5'b10011;
    for (int i = 4; i >= 0; i--) begin
      send(seq[i]);
      nvec++;
      if (ifc.detected !== 1'b0) begin
        nerr++;
        $display("FAIL cfg_drop bit %0d: got %b want 0", 5 - i, ifc.detected);
      end
    end
  endtask

  task automatic test_saturation();
    logic [5:0] seq;
    logic [3:0] tail;
    do_reset();
    seq  = 6'b110011;
    tail = 4'b0011;
    for (int i = 5; i >= 0; i--) send(seq[i]);
    for (int m = 2; m <= 5; m++) begin
      for (int i = 3; i >= 0; i--) send(tail[i]);
      nvec++;
      if (ifc.detected !== 1'b1 || ifc.match_cnt !== ((m > 3) ? 2'd3 : 2'(m))) begin
        nerr++;
        $display("FAIL sat match %0d: det=%b cnt=%0d want 1 %0d", m, ifc.detected, ifc.match_cnt, (m > 3) ? 3 : m);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [5:0] seq;
    logic [3:0] tail;
    seq  = 6'b110011;
    tail = 4'b0011;
    for (int i = 5; i >= 2; i--) send(seq[i]);
    do_reset();
    nvec++;
    if (ifc.match_cnt !== 2'd0 || ifc.detected !== 1'b0) begin
      nerr++;
      $display("FAIL mid_rst: cnt=%0d det=%b want 0 0", ifc.match_cnt, ifc.detected);
    end
    for (int i = 1; i >= 0; i--) begin
      send(seq[i]);
      nvec++;
      if (ifc.detected !== 1'b0) begin
        nerr++;
        $display("FAIL mid_tail bit %0d: got %b want 0", 2 - i, ifc.detected);
      end
    end
    // Change config, reset, and confirm the default pattern and overlap return.
    drive(1'b1, 16'b1010, 5'd4, 1'b0, 1'b0, 1'b0);
    send(1'b1); send(1'b0);
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      send(seq[i]);
      nvec++;
      if (ifc.detected !== (i == 0)) begin
        nerr++;
        $display("FAIL def_restore bit %0d: got %b want %b", 6 - i, ifc.detected, (i == 0));
      end
    end
    for (int i = 3; i >= 0; i--) send(tail[i]);
    nvec++;
    if (ifc.detected !== 1'b1 || ifc.match_cnt !== 2'd2) begin
      nerr++;
      $display("FAIL def_overlap: det=%b cnt=%0d want 1 2", ifc.detected, ifc.match_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.cfg_we = 1'b0; ifc.bit_valid = 1'b0; ifc.new_bit = 1'b0;
    ifc.cfg_pattern = '0; ifc.cfg_len = '0; ifc.cfg_overlap = 1'b0;
    test_reset();
    test_default();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_fill_guard();
    test_illegal_cfg();
    test_saturation();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
